// File: rtl/lite_cipher_core.sv
// lite_cipher_core: iterative rotate/XOR block cipher, one round per clock.
// Valid/ready on both sides, synchronous abort, all outputs registered.
module lite_cipher_core #(
    parameter int DATA_W = 8,
    parameter int ROUNDS = 10,
    parameter int CNT_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] key_in,
    input  logic              mode,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

    state_t              state_q;
    logic [DATA_W-1:0]   s_q;
    logic [DATA_W-1:0]   key_q;
    logic                mode_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [DATA_W-1:0]   data_out_q;

    logic [DATA_W-1:0]   rk;
    logic [DATA_W-1:0]   s_d;
    logic                last_rnd;

    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] x);
        return {x[DATA_W-2:0], x[DATA_W-1]};
    endfunction

    function automatic logic [DATA_W-1:0] rotr1(input logic [DATA_W-1:0] x);
        return {x[0], x[DATA_W-1:1]};
    endfunction

    // Round datapath: key schedule, one encrypt or decrypt round, last-round detect.
    always_comb begin
        rk       = key_q ^ DATA_W'(cnt_q);
        s_d      = mode_q ? (rotr1(s_q) ^ rk) : rotl1(s_q ^ rk);
        last_rnd = mode_q ? (cnt_q == '0) : (cnt_q == LAST_RND);
    end

    // Control FSM with registered handshake outputs and the round state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            key_q       <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            data_out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // abort has no meaning here; a request is accepted regardless
                    if (in_valid) begin
                        s_q        <= data_in;
                        key_q      <= key_in;
                        mode_q     <= mode;
                        cnt_q      <= mode ? LAST_RND : '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        s_q <= s_d;
                        if (last_rnd) begin
                            // counter parks on its final value instead of wrapping
                            state_q     <= DONE;
                            data_out_q  <= s_d;
                            out_valid_q <= 1'b1;
                        end else if (mode_q) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_lite_cipher_core.sv
// Self-checking bench for lite_cipher_core: four parameter sets checked
// against a plain-arithmetic model of the cipher rules.
module tb_lite_cipher_core;

    localparam int NI = 4;   // 0:(8,10) 1:(8,2) 2:(4,1) 3:(4,16)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NI-1:0] iv, md, ab, ordy;
    logic [NI-1:0] ir, ov, bsy;
    logic [7:0] din [NI];
    logic [7:0] kin [NI];
    logic [7:0] dout0, dout1;
    logic [3:0] dout2, dout3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lite_cipher_core #(.DATA_W(8), .ROUNDS(10)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .data_in(din[0]), .key_in(kin[0]), .mode(md[0]), .abort(ab[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout0), .busy(bsy[0]));

    lite_cipher_core #(.DATA_W(8), .ROUNDS(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .data_in(din[1]), .key_in(kin[1]), .mode(md[1]), .abort(ab[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout1), .busy(bsy[1]));

    lite_cipher_core #(.DATA_W(4), .ROUNDS(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .data_in(din[2][3:0]), .key_in(kin[2][3:0]), .mode(md[2]), .abort(ab[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .data_out(dout2), .busy(bsy[2]));

    lite_cipher_core #(.DATA_W(4), .ROUNDS(16)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .data_in(din[3][3:0]), .key_in(kin[3][3:0]), .mode(md[3]), .abort(ab[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .data_out(dout3), .busy(bsy[3]));

    function automatic int dw_of(input int id);
        return (id < 2) ? 8 : 4;
    endfunction

    function automatic int rn_of(input int id);
        case (id)
            0: return 10;
            1: return 2;
            2: return 1;
            default: return 16;
        endcase
    endfunction

    function automatic logic [7:0] get_dout(input int id);
        case (id)
            0: return dout0;
            1: return dout1;
            2: return {4'h0, dout2};
            default: return {4'h0, dout3};
        endcase
    endfunction

    // Reference: the round rules applied literally with integer arithmetic.
    function automatic logic [7:0] ref_model(input int id, input bit dec,
                                             input logic [7:0] d, input logic [7:0] k);
        int unsigned dw = dw_of(id);
        int unsigned nr = rn_of(id);
        int unsigned m  = (32'd1 << dw) - 1;
        int unsigned s  = d & m;
        int unsigned kk = k & m;
        for (int unsigned i = 0; i < nr; i++) begin
            if (!dec) begin
                s = (s ^ kk ^ i) & m;
                s = ((s << 1) | (s >> (dw - 1))) & m;
            end else begin
                s = ((s >> 1) | (s << (dw - 1))) & m;
                s = (s ^ kk ^ (nr - 1 - i)) & m;
            end
        end
        return s[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for acceptance; returns just after edge 0.
    task automatic start(input int id, input bit dec, input logic [7:0] d, input logic [7:0] k);
        int w = 0;
        md[id] = dec; din[id] = d; kin[id] = k; iv[id] = 1'b1;
        while (!ir[id] && w < 50) begin tick(); w++; end
        chk("accept_ready", 32'(ir[id]), 1);
        tick();
        iv[id] = 1'b0;
        din[id] = 8'($urandom);
        kin[id] = 8'($urandom);
        md[id] = 1'($urandom);
    endtask

    task automatic wait_ov(input int id, output int lat);
        lat = 0;
        while (!ov[id] && lat < 300) begin tick(); lat++; end
    endtask

    // Full transaction with out_ready held high.
    task automatic xact(input int id, input bit dec, input logic [7:0] d, input logic [7:0] k,
                        output logic [7:0] res, output int lat);
        ordy[id] = 1'b1;
        start(id, dec, d, k);
        wait_ov(id, lat);
        res = get_dout(id);
        tick();
        chk("ov_one_cycle", 32'(ov[id]), 0);
        chk("ir_after_hs", 32'(ir[id]), 1);
    endtask

    initial begin
        logic [7:0] p, k, c, r, hold, prev;
        int lat;
        iv = '0; md = '0; ab = '0; ordy = '0;
        for (int i = 0; i < NI; i++) begin din[i] = '0; kin[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) begin
            chk("rst_in_ready", 32'(ir[i]), 1);
            chk("rst_out_valid", 32'(ov[i]), 0);
            chk("rst_busy", 32'(bsy[i]), 0);
            chk("rst_data_out", 32'(get_dout(i)), 0);
        end

        // Known vectors on (8,2) and latency
        ordy[1] = 1'b1;
        start(1, 1'b0, 8'h01, 8'h00);
        chk("kv_busy_run", 32'(bsy[1]), 1);
        chk("kv_ir_run", 32'(ir[1]), 0);
        wait_ov(1, lat);
        chk("kv_lat", lat, 2);
        chk("kv_enc", 32'(dout1), 32'h06);
        tick();
        chk("kv_ov_pulse", 32'(ov[1]), 0);
        chk("kv_hold_idle", 32'(dout1), 32'h06);
        xact(1, 1'b1, 8'h06, 8'h00, r, lat);
        chk("kv_dec", 32'(r), 32'h01);
        chk("kv_dec_lat", lat, 2);

        // ROUNDS=1, DATA_W=4 boundary
        xact(2, 1'b0, 8'h03, 8'h01, r, lat);
        chk("r1_enc", 32'(r), 32'h4);
        chk("r1_lat", lat, 1);
        xact(2, 1'b1, 8'h04, 8'h01, r, lat);
        chk("r1_dec", 32'(r), 32'h3);

        // ROUNDS=16, DATA_W=4: every data/key pair, random direction
        for (int d = 0; d < 16; d++) begin
            for (int kk = 0; kk < 16; kk++) begin
                bit dec = 1'($urandom);
                xact(3, dec, 8'(d), 8'(kk), r, lat);
                chk("r16_model", 32'(r), 32'(ref_model(3, dec, 8'(d), 8'(kk))));
                chk("r16_lat", lat, 16);
            end
        end

        // Default parameters: random encrypt-then-decrypt round trips
        for (int i = 0; i < 1000; i++) begin
            p = 8'($urandom);
            k = 8'($urandom);
            xact(0, 1'b0, p, k, c, lat);
            chk("rt_enc_model", 32'(c), 32'(ref_model(0, 1'b0, p, k)));
            chk("rt_enc_lat", lat, 10);
            xact(0, 1'b1, c, k, r, lat);
            chk("rt_roundtrip", 32'(r), 32'(p));
        end

        // Backpressure in DONE
        ordy[0] = 1'b0;
        p = 8'($urandom); k = 8'($urandom);
        start(0, 1'b0, p, k);
        wait_ov(0, lat);
        chk("bp_lat", lat, 10);
        hold = dout0;
        chk("bp_model", 32'(hold), 32'(ref_model(0, 1'b0, p, k)));
        iv[0] = 1'b1; din[0] = ~p; kin[0] = k; md[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_ov_held", 32'(ov[0]), 1);
            chk("bp_dout_held", 32'(dout0), 32'(hold));
            chk("bp_ir_low", 32'(ir[0]), 0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        chk("bp_release_ov", 32'(ov[0]), 0);
        chk("bp_release_ir", 32'(ir[0]), 1);
        chk("bp_release_busy", 32'(bsy[0]), 0);

        // Abort in RUN at round 4
        prev = dout0;
        p = 8'($urandom); k = 8'($urandom);
        start(0, 1'b0, p, k);
        repeat (4) tick();
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        chk("ab_ir", 32'(ir[0]), 1);
        chk("ab_busy", 32'(bsy[0]), 0);
        chk("ab_dout", 32'(dout0), 32'(prev));
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin tick(); if (ov[0]) seen++; end
            chk("ab_no_ov", seen, 0);
        end
        xact(0, 1'b0, p, k, r, lat);
        chk("ab_after_model", 32'(r), 32'(ref_model(0, 1'b0, p, k)));

        // Abort in DONE under backpressure
        ordy[0] = 1'b0;
        start(0, 1'b1, p, k);
        wait_ov(0, lat);
        hold = dout0;
        chk("abd_model", 32'(hold), 32'(ref_model(0, 1'b1, p, k)));
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        chk("abd_ov", 32'(ov[0]), 0);
        chk("abd_ir", 32'(ir[0]), 1);
        chk("abd_dout", 32'(dout0), 32'(hold));

        // Abort in IDLE with a request: request still accepted
        ordy[0] = 1'b1;
        ab[0] = 1'b1;
        start(0, 1'b0, 8'h3C, 8'h99);
        ab[0] = 1'b0;
        chk("abi_busy", 32'(bsy[0]), 1);
        wait_ov(0, lat);
        chk("abi_lat", lat, 10);
        chk("abi_model", 32'(dout0), 32'(ref_model(0, 1'b0, 8'h3C, 8'h99)));
        tick();

        // Asynchronous reset mid-run
        start(0, 1'b0, 8'hA5, 8'h0F);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ir", 32'(ir[0]), 1);
        chk("arst_ov", 32'(ov[0]), 0);
        chk("arst_busy", 32'(bsy[0]), 0);
        chk("arst_dout", 32'(dout0), 0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin tick(); if (ov[0]) seen++; end
            chk("arst_no_ov", seen, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("arst_rel_ir", 32'(ir[0]), 1);
        xact(0, 1'b0, 8'h5A, 8'hC3, r, lat);
        chk("arst_5a_c3", 32'(r), 32'(ref_model(0, 1'b0, 8'h5A, 8'hC3)));
        chk("arst_lat", lat, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
